// File: rtl/jtframe_sdram_arb.sv
// Four-slot round-robin arbiter in front of a single-port SDRAM controller.
// Each slot keeps a one-entry read cache (last address and data) so that
// repeated reads of the same word complete without touching the SDRAM.
// A watchdog aborts transactions whose data never arrives after the ack.
module jtframe_sdram_arb #(
   parameter int AW   = 22,
   parameter int TOUT = 63
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              downloading,
   input  logic [3:0]        slot_req,
   input  logic [4*AW-1:0]   slot_addr,
   input  logic [3:0]        slot_we,
   input  logic [63:0]       slot_din,
   input  logic [7:0]        slot_wmask,
   output logic [127:0]      slot_dout,
   output logic [3:0]        slot_ok,
   output logic              read_req,
   output logic [AW-1:0]     sdram_addr,
   output logic              sdram_rnw,
   output logic [15:0]       data_write,
   output logic [1:0]        sdram_wrmask,
   output logic              refresh_en,
   input  logic              sdram_ack,
   input  logic              data_rdy,
   input  logic [31:0]       data_read,
   output logic              timeout_err
);

   localparam int CW = $clog2(TOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_r;
   logic [1:0]      slot_r;
   logic [1:0]      last_grant_r;
   logic [3:0]      mask_r;
   logic [3:0]      cache_valid_r;
   logic [AW-1:0]   cache_addr_r [4];
   logic [CW-1:0]   tout_cnt_r;

   logic [AW-1:0]   addr_s [4];
   logic [15:0]     din_s  [4];
   logic [1:0]      wm_s   [4];
   logic [3:0]      cand_s;
   logic [1:0]      idx_s;
   logic [1:0]      grant_s;
   logic            grant_ok_s;
   logic            hit_s;
   logic            done_s;

   // Split the packed slot buses into per-slot fields
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         addr_s[i] = slot_addr[i*AW +: AW];
         din_s[i]  = slot_din[i*16 +: 16];
         wm_s[i]   = slot_wmask[i*2 +: 2];
      end
   end

   // Round-robin pick starting after the last granted slot, plus cache lookup
   always_comb begin
      cand_s     = slot_req & ~mask_r;
      idx_s      = 2'd0;
      grant_s    = 2'd0;
      grant_ok_s = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx_s = last_grant_r + 2'(i);
         if (!grant_ok_s && cand_s[idx_s]) begin
            grant_ok_s = 1'b1;
            grant_s    = idx_s;
         end else begin
            grant_ok_s = grant_ok_s;
         end
      end
      hit_s = !slot_we[grant_s] && cache_valid_r[grant_s] &&
              (cache_addr_r[grant_s] == addr_s[grant_s]);
   end

   // Data arrives either together with the ack or later while waiting
   always_comb begin
      if (state_r == REQ) begin
         done_s = sdram_ack && data_rdy;
      end else if (state_r == WAIT) begin
         done_s = data_rdy;
      end else begin
         done_s = 1'b0;
      end
   end

   // Arbitration FSM with registered SDRAM-side and slot-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         slot_r        <= 2'd0;
         last_grant_r  <= 2'd3;
         mask_r        <= 4'b0000;
         cache_valid_r <= 4'b0000;
         for (int i = 0; i < 4; i++) cache_addr_r[i] <= {AW{1'b0}};
         tout_cnt_r    <= {CW{1'b0}};
         read_req      <= 1'b0;
         sdram_addr    <= {AW{1'b0}};
         sdram_rnw     <= 1'b1;
         data_write    <= 16'h0000;
         sdram_wrmask  <= 2'b00;
         refresh_en    <= 1'b0;
         slot_ok       <= 4'b0000;
         slot_dout     <= 128'd0;
         timeout_err   <= 1'b0;
      end else begin
         slot_ok    <= 4'b0000;
         refresh_en <= (state_r == IDLE) && (slot_req == 4'b0000) && !downloading;
         case (state_r)
            IDLE: begin
               mask_r <= 4'b0000;
               if (!downloading && grant_ok_s) begin
                  last_grant_r <= grant_s;
                  slot_r       <= grant_s;
                  if (hit_s) begin
                     state_r <= DONE;
                     slot_ok <= 4'b0001 << grant_s;
                  end else begin
                     state_r      <= REQ;
                     read_req     <= 1'b1;
                     sdram_addr   <= addr_s[grant_s];
                     sdram_rnw    <= !slot_we[grant_s];
                     data_write   <= din_s[grant_s];
                     sdram_wrmask <= slot_we[grant_s] ? wm_s[grant_s] : 2'b00;
                  end
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  read_req   <= 1'b0;
                  tout_cnt_r <= {CW{1'b0}};
                  state_r    <= data_rdy ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (data_rdy) begin
                  state_r <= DONE;
               end else if (tout_cnt_r == CW'(TOUT - 1)) begin
                  state_r               <= IDLE;
                  timeout_err           <= 1'b1;
                  cache_valid_r[slot_r] <= 1'b0;
               end else begin
                  tout_cnt_r <= tout_cnt_r + CW'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               mask_r  <= slot_ok;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
         if (done_s) begin
            slot_ok <= 4'b0001 << slot_r;
            if (sdram_rnw) begin
               slot_dout[{slot_r, 5'd0} +: 32] <= data_read;
               cache_addr_r[slot_r]            <= sdram_addr;
               cache_valid_r[slot_r]           <= 1'b1;
            end else begin
               cache_valid_r <= 4'b0000;
            end
         end
         if (downloading) cache_valid_r <= 4'b0000;
      end
   end

endmodule

// File: doc/jtframe_sdram_arb.md
JTFRAME_SDRAM_ARB -- requirements
Module: jtframe_sdram_arb

Interface
REQ-001 Parameter: AW, 22, word address width shared by slots and SDRAM port.
REQ-002 Parameter: TOUT, 63, cycles allowed from sdram_ack to data_rdy before abort.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, same as SDRAM controller.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 downloading  in  1  ROM load active; blocks new grants.
REQ-007 slot_req  in  4  per-slot request level, held until slot_ok.
REQ-008 slot_addr  in  4*AW  packed addresses, slot i at [i*AW +: AW].
REQ-009 slot_we  in  4  per-slot write (1) / read (0).
REQ-010 slot_din  in  64  packed write data, 16 bits per slot.
REQ-011 slot_wmask  in  8  packed byte masks, 2 bits per slot, 1 = byte masked.
REQ-012 slot_dout  out  128  packed read data, 32 bits per slot.
REQ-013 slot_ok  out  4  one-cycle completion pulse per slot.
REQ-014 read_req  out  1  request to SDRAM controller.
REQ-015 sdram_addr  out  AW  granted address.
REQ-016 sdram_rnw  out  1  1 = read, 0 = write.
REQ-017 data_write  out  16  granted write data.
REQ-018 sdram_wrmask  out  2  granted byte mask.
REQ-019 refresh_en  out  1  permits controller autorefresh.
REQ-020 sdram_ack  in  1  controller accepted request.
REQ-021 data_rdy  in  1  one-cycle pulse: read data valid / write done.
REQ-022 data_read  in  32  burst-of-two read data.
REQ-023 timeout_err  out  1  sticky: a transaction timed out.

Function
REQ-024 States IDLE, REQ, WAIT, DONE; arbitration only in IDLE.
REQ-025 Round-robin: search starts at (last_grant+1) mod 4; last_grant updates on every grant.
REQ-026 No grant while downloading=1; in-flight transaction completes normally.
REQ-027 Slot whose slot_ok pulsed is masked from arbitration in the IDLE cycle immediately after DONE.
REQ-028 Per-slot cache: last read address + data + valid bit; granted read with matching valid address -> DONE next cycle, slot_dout unchanged, no SDRAM access.
REQ-029 Miss or write: IDLE->REQ; read_req=1 with sdram_addr/rnw/data_write/wrmask registered from granted slot on the cycle after grant.
REQ-030 REQ: hold read_req and outputs stable until sdram_ack sampled 1; read_req=0 the next cycle; ->WAIT.
REQ-031 WAIT: data_rdy=1 -> read: slot_dout[slot] <= data_read, cache entry updated and valid; write: slot_dout unchanged; ->DONE.
REQ-032 data_rdy arriving in the same cycle as sdram_ack is honoured (REQ->DONE directly).
REQ-033 DONE: slot_ok[slot]=1 for exactly one cycle, then IDLE.
REQ-034 Any write completion clears valid bit of every slot cache.
REQ-035 downloading=1 clears all cache valid bits every cycle.
REQ-036 Timeout counter starts at ack; TOUT cycles in WAIT without data_rdy -> IDLE, no slot_ok, timeout_err=1, cached entry for that slot invalidated.
REQ-037 refresh_en=1 only in IDLE with slot_req==0 and downloading=0; registered.
REQ-038 Slot dropping slot_req mid-transaction: transaction still completes, slot_ok still pulses.
REQ-039 Reads always sdram_wrmask=2'b00, sdram_rnw=1.

Reset
REQ-040 rst_n=0 asynchronously: state IDLE, read_req 0, sdram_addr 0, sdram_rnw 1, data_write 0, sdram_wrmask 0, refresh_en 0, slot_ok 0, slot_dout 0, caches invalid, last_grant 3, timeout counter 0, timeout_err 0.
REQ-041 Reset asserted mid-transaction aborts it; no slot_ok after release.

Verification
REQ-042 slot_req=4'b1111 reads, controller acks after 2 cycles, data_rdy 5 cycles later -> grants 0,1,2,3 in order, each slot_dout = its data_read.
REQ-043 Slot 1 reads addr 0x000100 twice -> second slot_ok one cycle after grant, read_req stays 0, slot_dout unchanged.
REQ-044 Slot 2 writes 0x1234 mask 2'b01 then slot 1 rereads 0x000100 -> sdram_rnw=0, wrmask=01 during write; reread misses and issues read_req.
REQ-045 No data_rdy after ack -> after 63 cycles state IDLE, timeout_err=1, slot_ok stays 0.
REQ-046 downloading=1 during slot 0 WAIT -> slot 0 completes, slot 3 pending waits until downloading=0, refresh_en=0 throughout.
REQ-047 rst_n low while read_req=1 -> all outputs at reset values immediately, no slot_ok after release.
